// File: rtl/peripheral_interrupt_bank.sv
// peripheral_interrupt_bank
// NUM_BANKS pairs of PIR (flag) and PIE (enable) registers on the register file.
// Peripheral strobes latch into sticky flags. Software reads and writes both
// register sets. The block drives a PEIE-gated interrupt request, a PEIE-independent
// wake-up, and a registered lowest-index pending source.
// Optional feature: define PERIPH_INT_EDGE_DETECT_EN so that only rising edges of
// the strobes set flags. Without the macro, strobes act as levels.
module peripheral_interrupt_bank #(
  parameter int         NUM_BANKS     = 2,
  parameter logic [8:0] PIR_BASE_ADDR = 9'h00C,
  parameter logic [8:0] PIE_BASE_ADDR = 9'h08C,
  localparam int        SRC_W         = 8 * NUM_BANKS,
  localparam int        IDX_W         = (SRC_W > 1) ? $clog2(SRC_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             hit,
  input  logic [SRC_W-1:0] interrupt_strobes,
  input  logic             intcon_peie,
  output logic             peripheral_interrupt,
  output logic             wake_up,
  output logic             pending_valid,
  output logic [IDX_W-1:0] pending_index
);

  logic [NUM_BANKS-1:0][7:0] pir;
  logic [NUM_BANKS-1:0][7:0] pie;
  logic [NUM_BANKS-1:0][7:0] evt;
  logic [NUM_BANKS-1:0]      sel_pir;
  logic [NUM_BANKS-1:0]      sel_pie;
  logic [SRC_W-1:0]          pend_flat_p0;
  logic                      enc_valid_p0;
  logic [IDX_W-1:0]          enc_index_p0;

  // Lowest flat index wins, so scan from the top and let lower hits overwrite.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [SRC_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = SRC_W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

`ifdef PERIPH_INT_EDGE_DETECT_EN
  logic [SRC_W-1:0] strobes_q;

  // History of the strobes, used to turn a held level into a single event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobes_q <= '0;
    else     strobes_q <= interrupt_strobes;
  end

  assign evt = interrupt_strobes & ~strobes_q;
`else
  assign evt = interrupt_strobes;
`endif

  // Address decode: one select line per PIR and per PIE register.
  always_comb begin
    sel_pir = '0;
    sel_pie = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      sel_pir[k] = (addr == (PIR_BASE_ADDR + 9'(k)));
      sel_pie[k] = (addr == (PIE_BASE_ADDR + 9'(k)));
    end
  end

  assign hit = (|sel_pir) | (|sel_pie);

  // Read mux. The bus idles at zero when the block is not being read.
  always_comb begin
    data_out = 8'h00;
    if (rd_en) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (sel_pir[k])      data_out = pir[k];
        else if (sel_pie[k]) data_out = pie[k];
      end
    end
  end

  // Flag and enable registers. A strobe ORs into a software write, so an event
  // that coincides with a software clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pir <= '0;
      pie <= '0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (wr_en && sel_pir[k]) pir[k] <= data_in | evt[k];
        else                     pir[k] <= pir[k] | evt[k];
        if (wr_en && sel_pie[k]) pie[k] <= data_in;
      end
    end
  end

  // ---- stage p0: enabled pending flags and the priority encode ----
  assign pend_flat_p0         = pir & pie;
  assign wake_up              = |pend_flat_p0;
  assign peripheral_interrupt = wake_up & intcon_peie;
  assign enc_valid_p0         = |pend_flat_p0;
  assign enc_index_p0         = lowest_index(pend_flat_p0);

  // ---- stage p1: registered pending source for debug and vectoring ----
  // Registers the encoder result every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_valid <= 1'b0;
      pending_index <= '0;
    end else begin
      pending_valid <= enc_valid_p0;
      pending_index <= enc_index_p0;
    end
  end

endmodule

// File: tb/tb_peripheral_interrupt_bank.sv
// Scoreboard bench for peripheral_interrupt_bank. A reference model built from
// per-bank byte arrays predicts every cycle's outputs. A monitor on the falling
// edge pops the predictions and compares them with the DUT.
module tb_peripheral_interrupt_bank;
  localparam int         NB    = 2;
  localparam int         SW    = 8 * NB;
  localparam int         IW    = $clog2(SW);
  localparam logic [8:0] PIRB  = 9'h00C;
  localparam logic [8:0] PIEB  = 9'h08C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [8:0]    addr = '0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic          hit;
  logic [SW-1:0] strobes = '0;
  logic          peie = 1'b0;
  logic          pint;
  logic          wake;
  logic          pvalid;
  logic [IW-1:0] pindex;

  peripheral_interrupt_bank #(
    .NUM_BANKS(NB), .PIR_BASE_ADDR(PIRB), .PIE_BASE_ADDR(PIEB)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .data_in(data_in), .data_out(data_out), .hit(hit),
    .interrupt_strobes(strobes), .intcon_peie(peie),
    .peripheral_interrupt(pint), .wake_up(wake),
    .pending_valid(pvalid), .pending_index(pindex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    dout;
    logic          hit;
    logic          pint;
    logic          wake;
    logic          pv;
    logic [IW-1:0] pidx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0]    m_pir [NB];
  logic [7:0]    m_pie [NB];
  logic [SW-1:0] m_prev;
  logic          m_pv;
  int            m_pidx;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NB; k++) begin
      m_pir[k] = 8'h00;
      m_pie[k] = 8'h00;
    end
    m_prev = '0;
    m_pv   = 1'b0;
    m_pidx = 0;
  endfunction

  // Lowest enabled set flag, scanning the flat numbering 8*bank+bit.
  function automatic int model_first(output bit found);
    found = 0;
    for (int i = 0; i < SW; i++)
      if (m_pir[i / 8][i % 8] && m_pie[i / 8][i % 8]) begin
        found = 1;
        return i;
      end
    return 0;
  endfunction

  // One bus cycle: drive inputs, predict outputs, then advance the model at the edge.
  task automatic cyc(input logic [8:0] a, input bit rd, input bit wr,
                     input logic [7:0] d, input logic [SW-1:0] s, input bit pe);
    exp_t          e;
    bit            any;
    int            first;
    bit            in_pir, in_pie;
    int            kpir, kpie;
    logic [SW-1:0] ev;
    addr = a; rd_en = rd; wr_en = wr; data_in = d; strobes = s; peie = pe;
    in_pir = (a >= PIRB) && (a < PIRB + 9'(NB));
    in_pie = (a >= PIEB) && (a < PIEB + 9'(NB));
    kpir = int'(a) - int'(PIRB);
    kpie = int'(a) - int'(PIEB);
    first = model_first(any);
    e.hit  = in_pir || in_pie;
    e.dout = !rd ? 8'h00 : in_pir ? m_pir[kpir] : in_pie ? m_pie[kpie] : 8'h00;
    e.wake = any;
    e.pint = any && pe;
    e.pv   = m_pv;
    e.pidx = IW'(m_pidx);
    sb.push_back(e);
    @(posedge clk);
`ifdef PERIPH_INT_EDGE_DETECT_EN
    ev = s & ~m_prev;
`else
    ev = s;
`endif
    m_prev = s;
    m_pv   = any;
    m_pidx = any ? first : 0;
    for (int k = 0; k < NB; k++) begin
      if (wr && in_pir && kpir == k) m_pir[k] = d | ev[8*k +: 8];
      else                           m_pir[k] = m_pir[k] | ev[8*k +: 8];
      if (wr && in_pie && kpie == k) m_pie[k] = d;
    end
    #1;
  endtask

  task automatic idle(input bit pe);
    cyc(9'h000, 1'b0, 1'b0, 8'h00, '0, pe);
  endtask

  // Monitor: every predicted cycle is compared on the falling edge.
  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("data_out", int'(data_out), int'(e.dout));
      check("hit", int'(hit), int'(e.hit));
      check("peripheral_interrupt", int'(pint), int'(e.pint));
      check("wake_up", int'(wake), int'(e.wake));
      check("pending_valid", int'(pvalid), int'(e.pv));
      check("pending_index", int'(pindex), int'(e.pidx));
    end
  end

  // Pick an address from the block's registers, a neighbour just past each range, or noise.
  function automatic logic [8:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return PIRB + 9'($urandom_range(0, NB - 1));
      2, 3:    return PIEB + 9'($urandom_range(0, NB - 1));
      4:       return ($urandom_range(0, 1) != 0) ? PIRB + 9'(NB) : PIEB + 9'(NB);
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [SW-1:0] s;
      s = '0;
      for (int b = 0; b < SW; b++) s[b] = ($urandom_range(0, 9) == 0);
      cyc(rand_addr(), $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
          8'($urandom), s, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Strobe bit 3 with PIE1 = 08 and PEIE set
    cyc(PIEB, 0, 1, 8'h08, '0, 1);
    cyc(9'h000, 0, 0, 8'h00, SW'(16'h0008), 1);
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    // PEIE gating: wake without interrupt, then interrupt in the same cycle as PEIE
    cyc(PIRB, 1, 0, 8'h00, '0, 0);
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    // Software clear colliding with a strobe on the same bit
    cyc(PIRB, 0, 1, 8'h00, SW'(16'h0008), 1);
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    // Cross-bank priority: bit 7 beats bit 8, then bit 8 after PIR1 is cleared
    cyc(PIRB, 0, 1, 8'h00, '0, 1);
    cyc(PIEB + 9'd1, 0, 1, 8'h01, '0, 1);
    cyc(PIEB, 0, 1, 8'h80, '0, 1);
    cyc(9'h000, 0, 0, 8'h00, SW'(16'h0180), 1);
    idle(1); idle(1);
    cyc(PIRB, 0, 1, 8'h00, '0, 1);
    idle(1); idle(1);
    // Held strobe on bit 0 with a software clear in the middle
    cyc(PIRB + 9'd1, 0, 1, 8'h00, '0, 1);
    cyc(PIEB, 0, 1, 8'h01, '0, 1);
    cyc(PIRB, 1, 0, 8'h00, SW'(16'h0001), 1);
    cyc(PIRB, 1, 0, 8'h00, SW'(16'h0001), 1);
    cyc(PIRB, 1, 1, 8'h00, SW'(16'h0001), 1);
    cyc(PIRB, 1, 0, 8'h00, SW'(16'h0001), 1);
    cyc(PIRB, 1, 0, 8'h00, SW'(16'h0001), 1);
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    idle(1);

    random_run(400);

    // Set several flags and enables, then reset in the middle of a cycle with a write pending
    cyc(PIEB, 0, 1, 8'hFF, '0, 1);
    cyc(PIEB + 9'd1, 0, 1, 8'hFF, SW'(16'h5A3C), 1);
    idle(1); idle(1);
    #2;
    addr = PIRB; rd_en = 1'b1; wr_en = 1'b1; data_in = 8'hFF; strobes = '1;
    rst = 1'b1;
    #1;
    check("rst_peripheral_interrupt", int'(pint), 0);
    check("rst_wake_up", int'(wake), 0);
    check("rst_pending_valid", int'(pvalid), 0);
    check("rst_pending_index", int'(pindex), 0);
    check("rst_data_out", int'(data_out), 0);
    model_reset();
    @(posedge clk);
    addr = '0; rd_en = 1'b0; wr_en = 1'b0; data_in = '0; strobes = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    cyc(PIRB, 1, 0, 8'h00, '0, 1);
    cyc(PIRB + 9'(NB), 1, 0, 8'h00, '0, 1);
    cyc(PIEB + 9'(NB), 1, 1, 8'hFF, '0, 1);

    random_run(300);
    idle(0);
    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/peripheral_interrupt_bank.md
# peripheral_interrupt_bank

Parametrised peripheral interrupt unit for the midrange core, generalising the single PIR1/PIE1 pair to `NUM_BANKS` flag/enable register pairs (PIR1..PIRn, PIE1..PIEn). It latches peripheral interrupt strobes into flag registers and serves register-file reads and writes of the flag and enable registers. It produces the PEIE-gated peripheral interrupt request and a PEIE-independent wake-up request. It also produces a registered, priority-encoded index of the highest-priority pending source for debug and vectoring.

## Interface
Parameters:
- `NUM_BANKS`, 2, number of PIR/PIE pairs, legal range 1..4
- `PIR_BASE_ADDR`, 9'h00C, 9-bit register-file address of PIR1; PIRi sits at base+(i-1)
- `PIE_BASE_ADDR`, 9'h08C, 9-bit register-file address of PIE1; PIEi sits at base+(i-1)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `addr`  in  9  register-file address (bank-resolved, as presented to the regfile)
- `rd_en`  in  1  register read strobe
- `wr_en`  in  1  register write strobe
- `data_in`  in  8  write data (ALU output)
- `data_out`  out  8  read data; 0 when not selected
- `hit`  out  1  `addr` decodes to a PIR or PIE register of this block
- `interrupt_strobes`  in  8*NUM_BANKS  peripheral event requests; bit 8*(i-1)+b maps to PIRi bit b
- `intcon_peie`  in  1  INTCON.PEIE
- `peripheral_interrupt`  out  1  |(PIR & PIE) & PEIE
- `wake_up`  out  1  |(PIR & PIE), ignores PEIE
- `pending_valid`  out  1  registered: any enabled flag set
- `pending_index`  out  $clog2(8*NUM_BANKS) (minimum 1)  registered: lowest-numbered enabled set flag

## Operation
- Decode: `hit` is asserted when `addr` equals PIR_BASE_ADDR+k or PIE_BASE_ADDR+k for any k < NUM_BANKS. Decode is combinational.
- Read: `data_out` = the selected register when `rd_en & hit`, else 8'h00. Reads have no side effects.
- PIE write: when `wr_en & hit` selects PIEi, PIEi <= `data_in` on the next clock edge.
- PIR write: when `wr_en & hit` selects PIRi, PIRi <= `data_in | event_i` on the next clock edge.
  - The event term wins, so a strobe arriving in the same cycle as a software clear leaves that bit set.
- PIR without write: PIRi <= PIRi | event_i. Flags are sticky and are cleared only by software or reset.
- `event` is the strobe vector, conditioned per the Configuration section.
- `wake_up` and `peripheral_interrupt` are combinational from the registered PIR and PIE values plus `intcon_peie`.
- Priority encoder:
  - Lowest flat bit index (8*(i-1)+b) of PIR&PIE wins.
  - `pending_index` and `pending_valid` register this result every cycle.
  - When nothing is pending, `pending_index` holds 0 and `pending_valid`=0.
- Writes to addresses outside the block are ignored. Bits beyond NUM_BANKS do not exist.

## Timing
- Reset (async assert, sync deassert taken from the core's reset manager):
  - All PIR = 8'h00, all PIE = 8'h00.
  - `pending_valid`=0, `pending_index`=0.
  - Edge-detect history register = 0.
  - `peripheral_interrupt`=0, `wake_up`=0, `data_out`=0.
- Strobe asserted in cycle N: the PIR bit is visible in cycle N+1, `peripheral_interrupt`/`wake_up` follow in N+1, and `pending_*` update in N+2.
- Register write in cycle N: the new value is readable from N+1.
- Reset mid-operation discards all flags and any write in the same cycle. No partial state survives.
- Simultaneous events:
  - Multiple strobes in one cycle all latch.
  - A PIE write enabling a bit whose flag is already set raises `peripheral_interrupt` in N+1.

## Configuration
- `PERIPH_INT_EDGE_DETECT_EN` defined:
  - `event = strobes & ~strobes_q`, with `strobes_q` registered each cycle.
  - A strobe held high sets its flag once. Software can clear the flag while the strobe stays high, and the flag stays clear until the next rising edge.
  - Adds one 8*NUM_BANKS-bit history register, reset to 0.
- Not defined:
  - `event = strobes` (level).
  - A held strobe re-sets its flag every cycle, so a software clear does not persist while the strobe is high.

## Test plan
- Reset then strobe bit 3 for 1 cycle, PIE1=8'h08, PEIE=1:
  - PIR1 reads 8'h08.
  - `peripheral_interrupt`=1 one cycle after the strobe.
  - `pending_index`=3, `pending_valid`=1 two cycles after the strobe.
- PIE1=8'h08, PIR1 bit 3 set, PEIE=0:
  - `wake_up`=1 and `peripheral_interrupt`=0.
  - Setting PEIE=1 raises `peripheral_interrupt` in the same cycle.
- Write PIR1=8'h00 in the same cycle that strobe bit 3 pulses -> PIR1 reads 8'h08 next cycle.
- NUM_BANKS=2, PIE2=8'h01, PIE1=8'h80, strobe bits 7 and 8 together -> `pending_index`=7. After clearing PIR1, `pending_index`=8.
- Strobe bit 0 held high for 5 cycles with PIR1 cleared at cycle 2:
  - With `PERIPH_INT_EDGE_DETECT_EN`, PIR1 stays 8'h00.
  - Without it, PIR1 re-reads 8'h01.
- Set several flags, assert `rst` mid-cycle -> all outputs 0 immediately. Read of `PIR_BASE_ADDR` with `rd_en` after release returns 8'h00, and `hit`=0 for `PIR_BASE_ADDR+NUM_BANKS`.
